alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
// - Instruction-side producer for the ALU controller: decodes a 32-bit RV32I word into
//   ALUOp[1:0] and FuncCode[9:0] = {funct7, funct3}, the pair the ALU controller consumes.
// - Sits between fetch and execute. Valid/ready on both sides, DEPTH-entry output FIFO.
// PARAMETERS
// - DEPTH   2   output FIFO entries; power of two, >= 2
// - CNT_W   16  width of statistics counters (DECODE_STATS_EN only)
// PORTS
// - clk           in   1   single clock, rising edge
// - reset         in   1   asynchronous, active-high; clears all state
// - flush         in   1   synchronous; empties FIFO
// - in_valid      in   1   in_instr valid
// - in_ready      out  1   = !full (combinational)
// - in_instr      in   32  RV32I instruction word
// - out_valid     out  1   = !empty
// - out_ready     in   1   ALU controller side accepts head entry
// - out_alu_op    out  2   ALUOp of head entry
// - out_func_code out  10  FuncCode of head entry
// - out_rd        out  5   instr[11:7] of head entry
// - out_illegal   out  1   head entry is an unsupported opcode
// BEHAVIOUR
// - Decode (opcode = instr[6:0]):
//   0110011 R     -> ALUOp 10, FuncCode {instr[31:25], instr[14:12]}
//   0010011 I-ALU -> ALUOp 01, FuncCode {7'b0, funct3}; funct3=101 (SRLI/SRAI) keeps instr[31:25]
//   0000011 LOAD, 0100011 STORE, 0110111 LUI, 0010111 AUIPC -> ALUOp 00, FuncCode 0
//   any other     -> ALUOp 11, FuncCode 10'h3FF, illegal=1
// - Push when in_valid && in_ready; pop when out_valid && out_ready.
// - Latency: word accepted in cycle N appears at outputs in cycle N+1 (FIFO was empty).
// - Push and pop in same cycle (FIFO non-empty, not full): occupancy unchanged, order kept.
// - Full: in_ready=0; a push never lands in the cycle a full FIFO pops (no pass-through).
// - Empty: out_valid=0; out_alu_op/out_func_code/out_rd/out_illegal all 0.
// - Pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter 0..DEPTH.
// - flush: next cycle FIFO empty; flush beats a simultaneous push or pop (both dropped).
// - Reset (any time, incl. mid-transfer): FIFO empty, out_valid=0, data outputs 0,
//   in_ready=1 while reset is high and after release.
// - FIFO entries only change on push; head data stable while out_valid && !out_ready.
// CONFIGURATION
// - DECODE_STATS_EN defined: adds outputs stat_r, stat_i, stat_mem_u, stat_illegal
//   (CNT_W each); each counts pops of its class, saturates at all-ones, cleared by reset
//   only (not by flush).
// - DECODE_STATS_EN undefined: no counters, no stat_* ports; rest identical.
// TESTING
// - ADD x1,x2,x3 (0x003100B3), out_ready=1 -> next cycle out_alu_op=10, func=0, rd=1.
// - SUB 0x403100B3 -> alu_op=10, func=10'b0100000000; SRAI 0x4030D093 -> alu_op=01,
//   func=10'b0100000101; ANDI 0x0070F093 -> alu_op=01, func=10'b0000000111.
// - LUI 0x000010B7 -> alu_op=00, func=0; opcode 1110011 -> alu_op=11, func=3FF, illegal=1.
// - out_ready=0, push 3 words -> in_ready=0 after 2nd; head stays 1st word; release
//   out_ready -> 3 words in order, no loss or duplicate.
// - FIFO holding 2, assert flush with in_valid=1 -> next cycle out_valid=0, nothing kept;
//   assert reset mid-stream -> outputs 0 immediately, in_ready=1.
// - DECODE_STATS_EN: pop 2 R, 1 I, 1 illegal -> stat_r=2, stat_i=1, stat_illegal=1;
//   with CNT_W=2, pop 5 R -> stat_r stays 3.

Source files
------------

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - RV32I word to {ALUOp, FuncCode} decoder with a DEPTH-entry output FIFO
// Optional pop statistics counters are enabled by defining DECODE_STATS_EN.
module alu_op_decoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_alu_op,
  output logic [9:0]  out_func_code,
  output logic [4:0]  out_rd,
  output logic        out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_r,
  output logic [CNT_W-1:0] stat_i,
  output logic [CNT_W-1:0] stat_mem_u,
  output logic [CNT_W-1:0] stat_illegal
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_bad_params
    $error("alu_op_decoder: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  typedef struct packed {
    logic [1:0] alu_op;
    logic [9:0] func;
    logic [4:0] rd;
    logic       illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^in_instr[24:15];

  always_comb begin
    dec.alu_op  = 2'b11;
    dec.func    = 10'h3FF;
    dec.rd      = in_instr[11:7];
    dec.illegal = 1'b1;
    case (in_instr[6:0])
      7'b0110011: begin
        dec.alu_op  = 2'b10;
        dec.func    = {in_instr[31:25], in_instr[14:12]};
        dec.illegal = 1'b0;
      end
      7'b0010011: begin
        // Only the shift-right pair uses funct7 to tell SRLI from SRAI.
        dec.alu_op  = 2'b01;
        dec.func    = (in_instr[14:12] == 3'b101) ? {in_instr[31:25], in_instr[14:12]}
                                                  : {7'b0, in_instr[14:12]};
        dec.illegal = 1'b0;
      end
      7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111: begin
        dec.alu_op  = 2'b00;
        dec.func    = 10'h000;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  assign out_alu_op    = out_valid ? head.alu_op  : 2'b00;
  assign out_func_code = out_valid ? head.func    : 10'h000;
  assign out_rd        = out_valid ? head.rd      : 5'd0;
  assign out_illegal   = out_valid ? head.illegal : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef DECODE_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A pop dropped by flush is not counted; flush leaves the counters alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_r       <= '0;
      stat_i       <= '0;
      stat_mem_u   <= '0;
      stat_illegal <= '0;
    end else if (pop && !flush) begin
      if (head.illegal)                stat_illegal <= sat_inc(stat_illegal);
      else if (head.alu_op == 2'b10)   stat_r       <= sat_inc(stat_r);
      else if (head.alu_op == 2'b01)   stat_i       <= sat_inc(stat_i);
      else                             stat_mem_u   <= sat_inc(stat_mem_u);
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - directed-vector bench for alu_op_decoder
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_alu_op;
  logic [9:0]  out_func_code;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef DECODE_STATS_EN
  localparam int STAT_W = 2;
  logic [STAT_W-1:0] stat_r, stat_i, stat_mem_u, stat_illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] dv [10];
  logic [17:0] de [10];
  logic [17:0] got;

  always #5 clk = ~clk;

  alu_op_decoder #(
    .DEPTH(2)
`ifdef DECODE_STATS_EN
    , .CNT_W(STAT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_func_code(out_func_code),
    .out_rd(out_rd), .out_illegal(out_illegal)
`ifdef DECODE_STATS_EN
    , .stat_r(stat_r), .stat_i(stat_i), .stat_mem_u(stat_mem_u), .stat_illegal(stat_illegal)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
    tick(); tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    got = {out_alu_op, out_func_code, out_rd, out_illegal};
    vectors++; if (got !== 18'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", got); end
    reset = 1'b0;
    tick();
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
  endtask

  task automatic test_decode();
    dv = '{32'h003100B3, 32'h403100B3, 32'h4030D093, 32'h0070F093, 32'h40008093,
           32'h000010B7, 32'h00000117, 32'h0000A083, 32'h00000073, 32'h00000FFF};
    de = '{{2'b10, 10'h000, 5'd1, 1'b0}, {2'b10, 10'h100, 5'd1, 1'b0},
           {2'b01, 10'h105, 5'd1, 1'b0}, {2'b01, 10'h007, 5'd1, 1'b0},
           {2'b01, 10'h000, 5'd1, 1'b0}, {2'b00, 10'h000, 5'd1, 1'b0},
           {2'b00, 10'h000, 5'd2, 1'b0}, {2'b00, 10'h000, 5'd1, 1'b0},
           {2'b11, 10'h3FF, 5'd0, 1'b1}, {2'b11, 10'h3FF, 5'd31, 1'b1}};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = dv[i]; out_ready = 1'b1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL decode_pre_valid[%0d]: got %b expected 0", i, out_valid); end
      tick();
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL decode_latency[%0d]: got %b expected 1", i, out_valid); end
      got = {out_alu_op, out_func_code, out_rd, out_illegal};
      vectors++; if (got !== de[i]) begin miscompares++; $display("FAIL decode[%0d] instr %h: got %h expected %h", i, dv[i], got, de[i]); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL decode_pop[%0d]: got %b expected 0", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_rd [3];
    int n;
    logic acc;
    exp_rd = '{5'd1, 5'd2, 5'd3};
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h003100B3;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
    in_instr = 32'h00310133;
    tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got %b expected 0", in_ready); end
    in_instr = 32'h003101B3;
    tick(); tick();
    vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin miscompares++; $display("FAIL bp_head_hold: got valid=%b rd=%0d expected valid=1 rd=1", out_valid, out_rd); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        vectors++; if (out_rd !== exp_rd[n]) begin miscompares++; $display("FAIL bp_order[%0d]: got rd=%0d expected rd=%0d", n, out_rd, exp_rd[n]); end
        n++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL bp_count: got %0d expected 3", n); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h003100B3;
    tick(); tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup_full: got %b expected 0", in_ready); end
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00310133;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    got = {out_alu_op, out_func_code, out_rd, out_illegal};
    vectors++; if (got !== 18'h0) begin miscompares++; $display("FAIL flush_data: got %h expected 0", got); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_nothing_kept: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h403100B3;
    tick(); tick();
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_now: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    got = {out_alu_op, out_func_code, out_rd, out_illegal};
    vectors++; if (got !== 18'h0) begin miscompares++; $display("FAIL rst_mid_data: got %h expected 0", got); end
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_after: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
  endtask

`ifdef DECODE_STATS_EN
  task automatic test_stats();
    logic [31:0] words [8];
    words = '{32'h003100B3, 32'h403100B3, 32'h0070F093, 32'h00000073,
              32'h000010B7, 32'h003100B3, 32'h003100B3, 32'h003100B3};
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = words[i];
      tick();
      in_valid = 1'b0;
      tick();
      if (i == 4) begin
        vectors++; if (stat_r !== 2'd2 || stat_i !== 2'd1 || stat_illegal !== 2'd1 || stat_mem_u !== 2'd1) begin
          miscompares++; $display("FAIL stats_mix: got r=%0d i=%0d ill=%0d mem=%0d expected 2 1 1 1", stat_r, stat_i, stat_illegal, stat_mem_u); end
      end
    end
    vectors++; if (stat_r !== 2'd3) begin miscompares++; $display("FAIL stats_saturate: got %0d expected 3", stat_r); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef DECODE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
